elimax_ghrd_nios_sys_status_in: RTL and testbench
=================================================

ELIMAX_GHRD_NIOS_SYS_STATUS_IN -- requirements
Module: elimax_ghrd_nios_sys_status_in

Interface
REQ-001 Parameter WIDTH, default 8, number of monitored input bits (1..32) SHALL be supported.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive-mismatch cycles before a bit is accepted (>=1), SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  3  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data, zero wait state, read latency 0.
REQ-010 in_port  input  WIDTH  asynchronous external status inputs.
REQ-011 irq  output  1  level interrupt request.

Function
REQ-012 Register map SHALL be: 0 data (RO, debounced value); 1 edge_pol (RW, per bit 0=rising, 1=falling); 2 irqmask (RW); 3 edgecapture (write-1-to-clear); 4 irqmask set-bits (WO); 5 irqmask clear-bits (WO); 6,7 reserved.
REQ-013 readdata SHALL be combinational from address: selected register in bits [WIDTH-1:0], upper bits zero; addresses 4-7 SHALL read zero.
REQ-014 Write strobe SHALL be chipselect AND NOT write_n; writes to 0, 6, 7 SHALL be ignored.
REQ-015 Write to 4 SHALL give irqmask <= irqmask OR writedata; write to 5 SHALL give irqmask <= irqmask AND NOT writedata.
REQ-016 Each in_port bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-017 Per bit, a counter SHALL increment each cycle synchronized value differs from stable value, and clear to zero whenever they are equal.
REQ-018 Stable bit SHALL take the synchronized value at the DEBOUNCE_CYCLES-th consecutive mismatch edge, counter clearing the same edge; glitches shorter than DEBOUNCE_CYCLES cycles SHALL never change stable.
REQ-019 Latency: if edge N first samples a new in_port level into sync stage 1, stable SHALL update at edge N+1+DEBOUNCE_CYCLES.
REQ-020 An event SHALL occur on the edge stable changes in the direction selected by edge_pol; edgecapture bit SHALL set on that same edge.
REQ-021 Write to 3 SHALL clear edgecapture bits where writedata is 1; if an event and clear hit the same bit on the same edge, set SHALL win.
REQ-022 edge_pol change SHALL not itself create an event and SHALL apply from the next edge.
REQ-023 irq SHALL equal OR of (edgecapture AND irqmask), decoded from registered state only, no added latency.
REQ-024 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap.

Reset
REQ-025 reset_n low SHALL asynchronously clear synchronizers, counters, stable, edge_pol, irqmask, edgecapture; irq and readdata SHALL read 0.
REQ-026 An input held high through reset SHALL produce a rising event DEBOUNCE_CYCLES+2 edges after reset release if edge_pol bit is 0.
REQ-027 Reset mid-debounce SHALL discard partial counts; no event SHALL be pending after release.

Structure
REQ-028 Register address constants (0-5) SHALL live in shared package elimax_ghrd_nios_sys_pkg.
REQ-029 Sub-module elimax_ghrd_nios_sys_debounce (one bit: synchronizer, counter, stable, change pulse) SHALL be instantiated WIDTH times.
REQ-030 Top level SHALL hold only register file, edge qualification, read mux, irq.

Verification
REQ-031 in_port[0] 0->1 held, DEBOUNCE_CYCLES=16, irqmask=1 -> data bit0=1 and edgecapture=1 at edge N+17; irq high same cycle.
REQ-032 in_port[1] pulse 10 cycles -> data, edgecapture, irq unchanged.
REQ-033 edge_pol=0x04, in_port[2] 1->0 after settle -> edgecapture=0x04; write 0x04 to addr 3 -> reads 0, irq low.
REQ-034 Event on bit 3 coincident with write 0x08 to addr 3 -> edgecapture bit3 stays 1.
REQ-035 irqmask=0; write 0x0F to addr 4 then 0x05 to addr 5 -> addr 2 reads 0x0A; addr 5 reads 0.
REQ-036 Assert reset_n mid-debounce of bit 0 -> all reads 0, irq 0; in_port held high -> event at release+18 edges.

Source files
------------

// File: rtl/elimax_ghrd_nios_sys_pkg.sv
// Shared constants for the NIOS system status-input peripheral: bus widths
// and the Avalon-MM register word addresses.
package elimax_ghrd_nios_sys_pkg;

    localparam int BUS_W  = 32;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0; // debounced input value (RO)
    localparam logic [ADDR_W-1:0] ADDR_EDGE_POL = 3'd1; // 0 = rising, 1 = falling
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK  = 3'd2; // interrupt mask (RW)
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP  = 3'd3; // edge capture (write 1 to clear)
    localparam logic [ADDR_W-1:0] ADDR_MASK_SET = 3'd4; // OR writedata into irqmask
    localparam logic [ADDR_W-1:0] ADDR_MASK_CLR = 3'd5; // clear irqmask bits set in writedata

endpackage

// File: rtl/elimax_ghrd_nios_sys_status_in_if.sv
// Avalon-MM slave bus bundle for the status-input peripheral.
interface elimax_ghrd_nios_sys_status_in_if;
    import elimax_ghrd_nios_sys_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport slave  (input address, chipselect, write_n, writedata, output readdata);
    modport master (output address, chipselect, write_n, writedata, input readdata);

endinterface

// File: rtl/elimax_ghrd_nios_sys_debounce.sv
// One-bit input conditioner: 2-flop synchronizer followed by a consecutive
// mismatch counter. The stable value flips on the DEBOUNCE_CYCLES-th
// consecutive cycle the synchronized input disagrees with it; 'change' is
// high in the cycle whose closing edge performs that flip.
module elimax_ghrd_nios_sys_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic change
);
    import elimax_ghrd_nios_sys_pkg::*;

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mismatch_s;
    logic             accept_s;

    assign mismatch_s = sync2_r ^ stable_r;
    // Last mismatch of the run: the counter never goes past DEBOUNCE_CYCLES-1.
    assign accept_s   = mismatch_s && (cnt_r == CNT_LAST);
    assign stable     = stable_r;
    assign change     = accept_s;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Mismatch run counter and accepted (stable) value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= sync2_r;
        end else if (mismatch_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r    <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/elimax_ghrd_nios_sys_status_in.sv
// Status-input peripheral: WIDTH debounced inputs, per-bit edge polarity,
// sticky edge capture and a masked level interrupt on an Avalon-MM slave.
module elimax_ghrd_nios_sys_status_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    elimax_ghrd_nios_sys_status_in_if.slave    bus,
    input  logic [WIDTH-1:0]                   in_port,
    output logic                               irq
);
    import elimax_ghrd_nios_sys_pkg::*;

    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] change_s;
    logic [WIDTH-1:0] evt_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] wd_s;
    logic             wr_s;
    logic [WIDTH-1:0] edge_pol_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [BUS_W-1:0] rd_s;
    logic             unused_wd_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        elimax_ghrd_nios_sys_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .stable (data_s[i]),
            .change (change_s[i])
        );
    end

    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wd_s        = bus.writedata[WIDTH-1:0];
    assign unused_wd_s = ^bus.writedata;

    // A change qualifies when the old stable value equals the polarity bit:
    // 0 -> 1 with polarity 0 (rising), 1 -> 0 with polarity 1 (falling).
    assign evt_s = change_s & ~(data_s ^ edge_pol_r);

    // Write-1-to-clear mask for edge capture.
    always_comb begin
        clr_s = {WIDTH{1'b0}};
        if (wr_s && (bus.address == ADDR_EDGECAP)) begin
            clr_s = wd_s;
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Register file: polarity, mask, and edge capture (new events beat clears).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_pol_r <= {WIDTH{1'b0}};
            irqmask_r  <= {WIDTH{1'b0}};
            edgecap_r  <= {WIDTH{1'b0}};
        end else begin
            edgecap_r <= (edgecap_r & ~clr_s) | evt_s;
            if (wr_s) begin
                case (bus.address)
                    ADDR_EDGE_POL: edge_pol_r <= wd_s;
                    ADDR_IRQMASK:  irqmask_r  <= wd_s;
                    ADDR_MASK_SET: irqmask_r  <= irqmask_r | wd_s;
                    ADDR_MASK_CLR: irqmask_r  <= irqmask_r & ~wd_s;
                    default:       irqmask_r  <= irqmask_r;
                endcase
            end else begin
                irqmask_r <= irqmask_r;
            end
        end
    end

    // Zero-latency read mux; write-only and reserved words read as zero.
    always_comb begin
        rd_s = {BUS_W{1'b0}};
        case (bus.address)
            ADDR_DATA:     rd_s[WIDTH-1:0] = data_s;
            ADDR_EDGE_POL: rd_s[WIDTH-1:0] = edge_pol_r;
            ADDR_IRQMASK:  rd_s[WIDTH-1:0] = irqmask_r;
            ADDR_EDGECAP:  rd_s[WIDTH-1:0] = edgecap_r;
            default:       rd_s            = {BUS_W{1'b0}};
        endcase
    end

    assign bus.readdata = rd_s;
    assign irq          = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_elimax_ghrd_nios_sys_status_in.sv
// Self-checking bench for the status-input peripheral: directed scenarios
// plus randomized pin/bus activity against a window-based reference model.
module tb_elimax_ghrd_nios_sys_status_in;
    import elimax_ghrd_nios_sys_pkg::*;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] in_port = '0;
    logic         irq;

    elimax_ghrd_nios_sys_status_in_if bus();

    elimax_ghrd_nios_sys_status_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pin level seen at every edge since reset, plus the
    // architectural register values.
    logic [W-1:0] hist [0:8191];
    int           t = 0;
    logic [W-1:0] m_stable = '0, m_pol = '0, m_mask = '0, m_ec = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Synchronized level available k edges after reset (zero before reset release).
    function automatic logic sample(input int k, input int b);
        if (k < 0) return 1'b0;
        return hist[k][b];
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r[W-1:0] = m_stable;
            3'd1: r[W-1:0] = m_pol;
            3'd2: r[W-1:0] = m_mask;
            3'd3: r[W-1:0] = m_ec;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One clock edge: predict its effect, let it happen, then check irq.
    task automatic cycle();
        logic [W-1:0] chg, ev, clr, wd;
        logic         wr;
        logic [2:0]   a;
        bit           all_diff;
        hist[t] = in_port;
        wr  = bus.chipselect && !bus.write_n;
        a   = bus.address;
        wd  = bus.writedata[W-1:0];
        chg = '0;
        // A bit flips when the D synchronized samples ending two edges ago
        // all disagree with the current stable value.
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = t - D - 1; k <= t - 2; k++)
                if (sample(k, b) == m_stable[b]) all_diff = 1'b0;
            chg[b] = all_diff;
        end
        ev  = chg & ~(m_stable ^ m_pol);
        clr = (wr && a == 3'd3) ? wd : '0;
        if (wr) begin
            case (a)
                3'd1: m_pol = wd;
                3'd2: m_mask = wd;
                3'd4: m_mask = m_mask | wd;
                3'd5: m_mask = m_mask & ~wd;
                default: ;
            endcase
        end
        m_ec     = (m_ec & ~clr) | ev;
        m_stable = m_stable ^ chg;
        @(posedge clk);
        t++;
        #1;
        check_eq("irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        cycle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        v = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        for (int a = 0; a < 8; a++) begin
            read_reg(a[2:0], v);
            check_eq(tag, v, exp_read(a[2:0]));
        end
    endtask

    task automatic apply_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        #1;
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            read_reg(a[2:0], v);
            check_eq("rst_read", v, 32'd0);
        end
        t = 0; m_stable = '0; m_pol = '0; m_mask = '0; m_ec = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        in_port        = '0;

        apply_reset();
        repeat (3) cycle();

        // Mask set/clear words.
        bus_write(3'd4, 32'h0000_000F);
        bus_write(3'd5, 32'h0000_0005);
        read_reg(3'd2, v); check_eq("mask_setclr", v, 32'h0000_000A);
        read_reg(3'd5, v); check_eq("mask_clr_reads0", v, 32'd0);
        check_all("regs_a");

        // Bit 0 rising, accepted on the 18th edge after the pin change.
        bus_write(3'd2, 32'h0000_0001);
        in_port = 8'h01;
        repeat (17) cycle();
        read_reg(3'd0, v); check_eq("rise_early_data", v, 32'd0);
        cycle();
        read_reg(3'd0, v); check_eq("rise_data", v, 32'h0000_0001);
        read_reg(3'd3, v); check_eq("rise_edgecap", v, 32'h0000_0001);
        check_eq("rise_irq", {31'd0, irq}, 32'd1);

        // Ten-cycle glitch on bit 1 must be ignored.
        in_port = 8'h03;
        repeat (10) cycle();
        in_port = 8'h01;
        repeat (30) cycle();
        read_reg(3'd0, v); check_eq("glitch_data", v, 32'h0000_0001);
        read_reg(3'd3, v); check_eq("glitch_edgecap", v, 32'h0000_0001);
        bus_write(3'd3, 32'h0000_0001);
        read_reg(3'd3, v); check_eq("clr_bit0", v, 32'd0);

        // Falling-edge polarity on bit 2.
        bus_write(3'd1, 32'h0000_0004);
        bus_write(3'd2, 32'h0000_0005);
        in_port = 8'h05;
        repeat (20) cycle();
        read_reg(3'd3, v); check_eq("fall_norise", v, 32'd0);
        in_port = 8'h01;
        repeat (18) cycle();
        read_reg(3'd3, v); check_eq("fall_edgecap", v, 32'h0000_0004);
        check_eq("fall_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd3, 32'h0000_0004);
        read_reg(3'd3, v); check_eq("fall_clr", v, 32'd0);
        check_eq("fall_clr_irq", {31'd0, irq}, 32'd0);

        // Event on bit 3 on the same edge as its clear: set wins.
        in_port = 8'h09;
        repeat (17) cycle();
        bus_write(3'd3, 32'h0000_0008);
        read_reg(3'd3, v); check_eq("set_beats_clr", v, 32'h0000_0008);
        read_reg(3'd0, v); check_eq("set_beats_clr_data", v, 32'h0000_0009);
        check_all("regs_b");

        // Reset in the middle of a debounce run.
        in_port = 8'h00;
        repeat (20) cycle();
        in_port = 8'h01;
        repeat (8) cycle();
        apply_reset();
        repeat (17) cycle();
        read_reg(3'd0, v); check_eq("post_rst_early", v, 32'd0);
        read_reg(3'd3, v); check_eq("post_rst_noevt", v, 32'd0);
        cycle();
        read_reg(3'd0, v); check_eq("post_rst_data", v, 32'h0000_0001);
        read_reg(3'd3, v); check_eq("post_rst_edgecap", v, 32'h0000_0001);
        check_all("regs_c");

        // Randomized pins and bus traffic.
        bus_write(3'd1, $urandom);
        bus_write(3'd2, $urandom);
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 19) == 0) in_port[b] = ~in_port[b];
            case ($urandom_range(0, 9))
                0: bus_write(3'($urandom_range(0, 7)), $urandom);
                1: begin check_all("rand_read"); cycle(); end
                default: cycle();
            endcase
        end
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
